// File: rtl/qbus_sync_slave.sv
// qbus_sync_slave: clocked QBUS slave front end. Synchronizes the raw bus
// receiver lines, decodes an I/O-page register window and turns DATI, DATO
// and DATIO bus cycles into single-cycle strobes for a synchronous register
// file, driving DAL, DALtx and TRPLY back to the transceivers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for SYNC to rise; address is latched only here
// NOMATCH   | address not ours; stay silent until SYNC falls
// ADDR      | address matched; waiting for DIN or DOUT (or SYNC fall)
// RD_WAIT   | rd_strobe issued; capture rd_data, enable DAL transmitters
// RD_DRIVE  | data on DAL, assert RPLY until DIN is released
// WR_ACK    | wr_strobe issued; assert RPLY until DOUT is released
module qbus_sync_slave #(
  parameter logic [12:0] ADDR_BASE   = 13'o17760,
  parameter int          COUNT       = 4,
  parameter int          IDX_W       = 6,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RSYNC,
  input  logic             RDIN,
  input  logic             RDOUT,
  input  logic             RBS7,
  input  logic [21:0]      DAL_in,
  output logic [21:0]      DAL_out,
  output logic             DALtx,
  output logic             TRPLY,
  output logic [IDX_W-1:0] reg_index,
  output logic             rd_strobe,
  input  logic [15:0]      rd_data,
  output logic             wr_strobe,
  output logic [15:0]      wr_data
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] NOMATCH  = 3'd1;
  localparam logic [2:0] ADDR     = 3'd2;
  localparam logic [2:0] RD_WAIT  = 3'd3;
  localparam logic [2:0] RD_DRIVE = 3'd4;
  localparam logic [2:0] WR_ACK   = 3'd5;

  localparam logic [11:0] COUNT_W = 12'(COUNT);

  // control bits packed as {BS7, DOUT, DIN, SYNC}
  logic [3:0]  ctl_sync [SYNC_STAGES];
  logic [15:0] dal_sync [SYNC_STAGES];
  logic [3:0]  ctl_lvl;
  logic [2:0]  ctl_prev;
  logic [2:0]  rise_q;
  logic        sync_fall_q;
  logic [15:0] dal_lvl;
  logic [11:0] off;
  logic        hit;
  logic [2:0]  state;
  logic [5:0]  unused_dal_hi;

  // Upper DAL lines carry nothing this slave decodes.
  assign unused_dal_hi = DAL_in[21:16];

  assign ctl_lvl = ctl_sync[SYNC_STAGES-1];
  assign dal_lvl = dal_sync[SYNC_STAGES-1];

  // Word offset into the window; wraps so addresses below the base miss.
  assign off = dal_lvl[12:1] - ADDR_BASE[12:1];
  assign hit = (off < COUNT_W) && !dal_lvl[0] && ctl_lvl[3];

  // Synchronizer chain for controls and DAL, plus registered edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ctl_sync[i] <= '0;
        dal_sync[i] <= '0;
      end
      ctl_prev    <= '0;
      rise_q      <= '0;
      sync_fall_q <= 1'b0;
    end else begin
      ctl_sync[0] <= {RBS7, RDOUT, RDIN, RSYNC};
      dal_sync[0] <= DAL_in[15:0];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ctl_sync[i] <= ctl_sync[i-1];
        dal_sync[i] <= dal_sync[i-1];
      end
      ctl_prev    <= ctl_lvl[2:0];
      rise_q      <= ctl_lvl[2:0] & ~ctl_prev;
      sync_fall_q <= ~ctl_lvl[0] & ctl_prev[0];
    end
  end

  // Bus-cycle sequencer; strobes default low so each lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      DAL_out   <= '0;
      DALtx     <= 1'b0;
      TRPLY     <= 1'b0;
      reg_index <= '0;
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
      wr_data   <= '0;
    end else begin
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_q[0]) begin
            if (hit) begin
              reg_index <= off[IDX_W-1:0];
              state     <= ADDR;
            end else begin
              state <= NOMATCH;
            end
          end
        end
        NOMATCH: begin
          if (sync_fall_q) state <= IDLE;
        end
        ADDR: begin
          if (sync_fall_q) begin
            state <= IDLE;
          end else if (rise_q[1]) begin
            rd_strobe <= 1'b1;
            state     <= RD_WAIT;
          end else if (rise_q[2]) begin
            wr_data   <= dal_lvl;
            wr_strobe <= 1'b1;
            state     <= WR_ACK;
          end
        end
        RD_WAIT: begin
          if (sync_fall_q) begin
            DALtx <= 1'b0;
            TRPLY <= 1'b0;
            state <= IDLE;
          end else begin
            DAL_out <= {6'b0, rd_data};
            DALtx   <= 1'b1;
            state   <= RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (sync_fall_q) begin
            DALtx <= 1'b0;
            TRPLY <= 1'b0;
            state <= IDLE;
          end else if (!ctl_lvl[1]) begin
            DALtx <= 1'b0;
            TRPLY <= 1'b0;
            state <= ADDR;
          end else begin
            TRPLY <= 1'b1;
          end
        end
        WR_ACK: begin
          if (sync_fall_q) begin
            DALtx <= 1'b0;
            TRPLY <= 1'b0;
            state <= IDLE;
          end else if (!ctl_lvl[2]) begin
            TRPLY <= 1'b0;
            state <= ADDR;
          end else begin
            TRPLY <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
